native_rr_arbiter: RTL and testbench

- Shares one native-bus target (valid/ready/addr/wdata/wstrb/rdata) between N_MASTERS native requesters.
- Typical target is an AXI4-Lite-to-native adapter's downstream memory, or a native RAM/peripheral.
- Round-robin arbitration with a registered grant.
- The grant is held from selection until the target's single-cycle ready acknowledge, then rotates.

---
 rtl/native_rr_arbiter_pkg.sv | 29 ++
 rtl/native_rr_pick.sv | 43 ++++
 rtl/native_rr_arbiter.sv | 125 ++++++++++++
 tb/tb_native_rr_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/native_rr_arbiter_pkg.sv
// Shared definitions for the native-bus round-robin arbiter slice.
// Latency: none, declarations only.
// Backpressure: not applicable.
// Contents: default native-bus field widths, arbiter FSM state encoding,
// and a clog2 helper used to size the rotation pointer.
package native_rr_arbiter_pkg;

    localparam int NATIVE_ADDR_W = 32;
    localparam int NATIVE_DATA_W = 32;
    localparam int NATIVE_STRB_W = NATIVE_DATA_W / 8;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

    // Ceiling log2, never below 1 so a pointer always has at least one bit.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/native_rr_pick.sv
// Round-robin pick: one-hot winner among req_i, searching upward from ptr_i.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to register the winner.
// Ports: req_i (request vector), ptr_i (search start, always < N),
//        winner_o (one-hot, 0 if no request), any_req_o.
module native_rr_pick #(
    parameter int N  = 2,
    parameter int PW = 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  winner_o,
    output logic          any_req_o
);

    logic [2*N-1:0] req_dbl;
    logic [2*N-1:0] oh_dbl;
    logic [N-1:0]   req_rot;
    logic [N-1:0]   rot_oh;
    logic           found;

    always_comb begin
        // Rotate right by ptr so bit 0 of req_rot is the requester at ptr;
        // the doubled vector makes the rotation wrap modulo N.
        req_dbl = {req_i, req_i} >> ptr_i;
        req_rot = req_dbl[N-1:0];

        rot_oh = '0;
        found  = 1'b0;
        for (int j = 0; j < N; j++) begin
            if (!found && req_rot[j]) begin
                rot_oh[j] = 1'b1;
                found     = 1'b1;
            end
        end

        // Rotate the one-hot back left by ptr to absolute master indices.
        oh_dbl    = {rot_oh, rot_oh} << ptr_i;
        winner_o  = oh_dbl[2*N-1:N];
        any_req_o = |req_i;
    end

endmodule

// File: rtl/native_rr_arbiter.sv
// Round-robin arbiter sharing one native-bus target between N_MASTERS requesters.
// Latency: one arbitration cycle in IDLE, then s_valid; m_ready follows s_ready same cycle.
// Backpressure: grant held until the target's s_ready pulse; owner dropping valid aborts.
// Ports: clk/rst (sync, active-high); m_* flattened per-master request side
//        (master i at [i*W +: W]); s_* target side; grant one-hot owner; busy = BUSY state.
module native_rr_arbiter
    import native_rr_arbiter_pkg::*;
#(
    parameter int N_MASTERS  = 2,
    parameter int ADDR_WIDTH = NATIVE_ADDR_W,
    parameter int DATA_WIDTH = NATIVE_DATA_W,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [N_MASTERS-1:0]             m_valid,
    output logic [N_MASTERS-1:0]             m_ready,
    input  logic [N_MASTERS*ADDR_WIDTH-1:0]  m_addr,
    input  logic [N_MASTERS*DATA_WIDTH-1:0]  m_wdata,
    input  logic [N_MASTERS*STRB_WIDTH-1:0]  m_wstrb,
    output logic [DATA_WIDTH-1:0]            m_rdata,
    output logic                             s_valid,
    input  logic                             s_ready,
    output logic [ADDR_WIDTH-1:0]            s_addr,
    output logic [DATA_WIDTH-1:0]            s_wdata,
    output logic [STRB_WIDTH-1:0]            s_wstrb,
    input  logic [DATA_WIDTH-1:0]            s_rdata,
    output logic [N_MASTERS-1:0]             grant,
    output logic                             busy
);

    localparam int PW = clog2(N_MASTERS);
    localparam logic [PW-1:0] LAST_IDX = PW'(N_MASTERS - 1);

    arb_state_e           state_q, state_d;
    logic [N_MASTERS-1:0] grant_q, grant_d;
    logic [PW-1:0]        ptr_q, ptr_d;

    logic [N_MASTERS-1:0] winner;
    logic                 any_req;
    logic [PW-1:0]        owner_idx;
    logic [PW-1:0]        ptr_after_owner;
    logic                 owner_vld;
    logic                 busy_st;

    native_rr_pick #(
        .N  (N_MASTERS),
        .PW (PW)
    ) u_pick (
        .req_i     (m_valid),
        .ptr_i     (ptr_q),
        .winner_o  (winner),
        .any_req_o (any_req)
    );

    always_comb begin
        owner_idx = '0;
        for (int i = 0; i < N_MASTERS; i++) begin
            if (grant_q[i]) begin
                owner_idx = PW'(i);
            end
        end
        // Explicit wrap: N_MASTERS need not be a power of two.
        ptr_after_owner = (owner_idx == LAST_IDX) ? '0 : owner_idx + 1'b1;
    end

    assign busy_st   = (state_q == BUSY);
    assign owner_vld = |(m_valid & grant_q);

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    grant_d = winner;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (s_ready) begin
                    ptr_d   = ptr_after_owner;
                    grant_d = '0;
                    state_d = IDLE;
                end else if (!owner_vld) begin
                    // Owner withdrew: release without advancing fairness pointer.
                    grant_d = '0;
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
        end
    end

    // AND-OR mux on the registered grant: outputs are zero whenever grant is zero.
    always_comb begin
        s_addr  = '0;
        s_wdata = '0;
        s_wstrb = '0;
        for (int i = 0; i < N_MASTERS; i++) begin
            s_addr  = s_addr  | (m_addr [i*ADDR_WIDTH +: ADDR_WIDTH] & {ADDR_WIDTH{grant_q[i]}});
            s_wdata = s_wdata | (m_wdata[i*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{grant_q[i]}});
            s_wstrb = s_wstrb | (m_wstrb[i*STRB_WIDTH +: STRB_WIDTH] & {STRB_WIDTH{grant_q[i]}});
        end
    end

    assign s_valid = busy_st & owner_vld;
    assign m_ready = busy_st ? (grant_q & {N_MASTERS{s_ready}}) : '0;
    assign m_rdata = s_rdata;
    assign grant   = grant_q;
    assign busy    = busy_st;

endmodule

// File: tb/tb_native_rr_arbiter.sv
// Testbench for native_rr_arbiter: N=3 cycle table plus N=2 hand sequences.
// Latency: drives inputs 1 time unit after posedge, samples on negedge.
// Backpressure: bench plays the target, stalling s_ready where sequences need it.
module tb_native_rr_arbiter;

    logic clk;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks;
    int errors;

    // ---------------- N=3 instance ----------------
    logic        rst3;
    logic [2:0]  mv3;
    logic [2:0]  mr3;
    logic [95:0] maddr3;
    logic [95:0] mwd3;
    logic [11:0] mws3;
    logic [31:0] mrd3;
    logic        sv3;
    logic        sr3;
    logic [31:0] sa3;
    logic [31:0] swd3;
    logic [3:0]  sws3;
    logic [31:0] srd3;
    logic [2:0]  gr3;
    logic        busy3;

    native_rr_arbiter #(.N_MASTERS(3), .ADDR_WIDTH(32), .DATA_WIDTH(32), .STRB_WIDTH(4)) u_dut3 (
        .clk(clk), .rst(rst3), .m_valid(mv3), .m_ready(mr3), .m_addr(maddr3),
        .m_wdata(mwd3), .m_wstrb(mws3), .m_rdata(mrd3), .s_valid(sv3), .s_ready(sr3),
        .s_addr(sa3), .s_wdata(swd3), .s_wstrb(sws3), .s_rdata(srd3), .grant(gr3), .busy(busy3)
    );

    // ---------------- N=2 instance ----------------
    logic        rst2;
    logic [1:0]  mv2;
    logic [1:0]  mr2;
    logic [63:0] maddr2;
    logic [63:0] mwd2;
    logic [7:0]  mws2;
    logic [31:0] mrd2;
    logic        sv2;
    logic        sr2;
    logic [31:0] sa2;
    logic [31:0] swd2;
    logic [3:0]  sws2;
    logic [31:0] srd2;
    logic [1:0]  gr2;
    logic        busy2;

    native_rr_arbiter #(.N_MASTERS(2), .ADDR_WIDTH(32), .DATA_WIDTH(32), .STRB_WIDTH(4)) u_dut2 (
        .clk(clk), .rst(rst2), .m_valid(mv2), .m_ready(mr2), .m_addr(maddr2),
        .m_wdata(mwd2), .m_wstrb(mws2), .m_rdata(mrd2), .s_valid(sv2), .s_ready(sr2),
        .s_addr(sa2), .s_wdata(swd2), .s_wstrb(sws2), .s_rdata(srd2), .grant(gr2), .busy(busy2)
    );

    // ---------------- scoreboard ----------------
    typedef struct {
        int          idx;
        logic [31:0] rdata;
    } sb_t;
    sb_t sbq[$];

    typedef struct {
        logic [2:0] mv;
        logic       sr;
        logic [2:0] e_grant;
        logic       e_sv;
        logic [2:0] e_mr;
        logic       e_busy;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic sb_push(input int idx, input logic [31:0] rd);
        sb_t e;
        e.idx   = idx;
        e.rdata = rd;
        sbq.push_back(e);
    endtask

    task automatic sb_pop(input string name, input int idx, input logic [31:0] rd);
        sb_t e;
        if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: got ack from master %0d expected no ack", name, idx);
        end else begin
            e = sbq.pop_front();
            chk({name, "_idx"}, 64'(idx), 64'(e.idx));
            chk({name, "_rdata"}, 64'(rd), 64'(e.rdata));
        end
    endtask

    function automatic int oh2idx(input logic [2:0] oh);
        int r;
        r = -1;
        for (int i = 0; i < 3; i++) begin
            if (oh[i]) r = i;
        end
        return r;
    endfunction

    function automatic logic [31:0] addr3_of(input logic [2:0] g);
        logic [31:0] a;
        a = 32'h0;
        for (int i = 0; i < 3; i++) begin
            if (g[i]) a = a | (32'h100 * 32'(i + 1));
        end
        return a;
    endfunction

    function automatic vec_t mkv(input logic [2:0] mv, input logic sr, input logic [2:0] eg,
                                 input logic esv, input logic [2:0] emr, input logic eb);
        vec_t v;
        v.mv = mv; v.sr = sr; v.e_grant = eg; v.e_sv = esv; v.e_mr = emr; v.e_busy = eb;
        return v;
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    vec_t        vecs[21];
    logic [31:0] mem_word;
    bit          got_ack;

    initial begin
        checks = 0;
        errors = 0;

        vecs[0]  = mkv(3'b111, 1'b0, 3'b000, 1'b0, 3'b000, 1'b0);
        vecs[1]  = mkv(3'b111, 1'b1, 3'b001, 1'b1, 3'b001, 1'b1);
        vecs[2]  = mkv(3'b110, 1'b0, 3'b000, 1'b0, 3'b000, 1'b0);
        vecs[3]  = mkv(3'b110, 1'b1, 3'b010, 1'b1, 3'b010, 1'b1);
        vecs[4]  = mkv(3'b100, 1'b0, 3'b000, 1'b0, 3'b000, 1'b0);
        vecs[5]  = mkv(3'b100, 1'b1, 3'b100, 1'b1, 3'b100, 1'b1);
        vecs[6]  = mkv(3'b000, 1'b1, 3'b000, 1'b0, 3'b000, 1'b0); // s_ready in IDLE ignored
        vecs[7]  = mkv(3'b101, 1'b0, 3'b000, 1'b0, 3'b000, 1'b0); // pointer wrapped to 0
        vecs[8]  = mkv(3'b101, 1'b0, 3'b001, 1'b1, 3'b000, 1'b1); // target stall
        vecs[9]  = mkv(3'b101, 1'b1, 3'b001, 1'b1, 3'b001, 1'b1);
        vecs[10] = mkv(3'b100, 1'b0, 3'b000, 1'b0, 3'b000, 1'b0);
        vecs[11] = mkv(3'b100, 1'b1, 3'b100, 1'b1, 3'b100, 1'b1);
        vecs[12] = mkv(3'b100, 1'b0, 3'b000, 1'b0, 3'b000, 1'b0); // single requester again
        vecs[13] = mkv(3'b100, 1'b1, 3'b100, 1'b1, 3'b100, 1'b1);
        vecs[14] = mkv(3'b010, 1'b0, 3'b000, 1'b0, 3'b000, 1'b0);
        vecs[15] = mkv(3'b101, 1'b0, 3'b010, 1'b0, 3'b000, 1'b1); // owner 1 aborts
        vecs[16] = mkv(3'b101, 1'b0, 3'b000, 1'b0, 3'b000, 1'b0); // ptr still 0 -> master 0
        vecs[17] = mkv(3'b101, 1'b1, 3'b001, 1'b1, 3'b001, 1'b1);
        vecs[18] = mkv(3'b100, 1'b0, 3'b000, 1'b0, 3'b000, 1'b0);
        vecs[19] = mkv(3'b000, 1'b0, 3'b100, 1'b0, 3'b000, 1'b1); // abort with no one left
        vecs[20] = mkv(3'b000, 1'b0, 3'b000, 1'b0, 3'b000, 1'b0);

        rst3 = 1'b1; mv3 = '0; sr3 = 1'b0; srd3 = '0;
        maddr3 = {32'h300, 32'h200, 32'h100};
        mwd3   = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
        mws3   = {4'h0, 4'h3, 4'hF};
        rst2 = 1'b1; mv2 = '0; sr2 = 1'b0; srd2 = '0;
        maddr2 = {32'h40, 32'h0}; mwd2 = '0; mws2 = '0;
        mem_word = '0;

        next_cycle();
        next_cycle();
        settle();
        chk("rst3_grant", 64'(gr3), 64'(0));
        chk("rst3_svalid", 64'(sv3), 64'(0));
        chk("rst3_mready", 64'(mr3), 64'(0));
        chk("rst3_busy", 64'(busy3), 64'(0));
        chk("rst3_saddr", 64'(sa3), 64'(0));
        chk("rst2_grant", 64'(gr2), 64'(0));
        chk("rst2_saddr", 64'(sa2), 64'(0));

        // ---------------- N=3 table ----------------
        next_cycle();
        rst3 = 1'b0;
        for (int k = 0; k < 21; k++) begin
            if (k != 0) next_cycle();
            mv3  = vecs[k].mv;
            sr3  = vecs[k].sr;
            srd3 = 32'hA000_0000 + 32'(k);
            if (vecs[k].e_mr != 3'b000) sb_push(oh2idx(vecs[k].e_mr), srd3);
            settle();
            chk($sformatf("v%0d_grant", k), 64'(gr3), 64'(vecs[k].e_grant));
            chk($sformatf("v%0d_svalid", k), 64'(sv3), 64'(vecs[k].e_sv));
            chk($sformatf("v%0d_mready", k), 64'(mr3), 64'(vecs[k].e_mr));
            chk($sformatf("v%0d_busy", k), 64'(busy3), 64'(vecs[k].e_busy));
            chk($sformatf("v%0d_saddr", k), 64'(sa3), 64'(addr3_of(vecs[k].e_grant)));
            if (mr3 != 3'b000) sb_pop($sformatf("v%0d_ack", k), oh2idx(mr3), mrd3);
        end
        chk("t3_sb_drained", 64'(sbq.size()), 64'(0));
        sbq.delete();

        // ---------------- N=2: single request from master 1 ----------------
        next_cycle();
        rst2 = 1'b0;
        mv2  = 2'b10;
        settle();
        chk("a_idle_svalid", 64'(sv2), 64'(0));
        next_cycle();
        sr2  = 1'b1;
        srd2 = 32'h1234_5678;
        sb_push(1, 32'h1234_5678);
        settle();
        chk("a_svalid", 64'(sv2), 64'(1));
        chk("a_saddr", 64'(sa2), 64'(32'h40));
        chk("a_mready", 64'(mr2), 64'(2'b10));
        if (mr2 != 2'b00) sb_pop("a_ack", (mr2 == 2'b10) ? 1 : 0, mrd2);
        next_cycle();
        sr2 = 1'b0;
        mv2 = 2'b00;
        settle();
        chk("a_grant_after", 64'(gr2), 64'(0));
        chk("a_busy_after", 64'(busy2), 64'(0));

        // ---------------- N=2: write master 0, then read master 1 with stall ----------------
        next_cycle();
        mv2    = 2'b01;
        maddr2 = {32'h80, 32'h80};
        mwd2   = {32'h0, 32'hDEAD_BEEF};
        mws2   = {4'h0, 4'hF};
        settle();
        next_cycle();
        sr2 = 1'b1;
        sb_push(0, 32'h0);
        srd2 = 32'h0;
        settle();
        chk("w_wstrb", 64'(sws2), 64'(4'hF));
        chk("w_wdata", 64'(swd2), 64'(32'hDEAD_BEEF));
        chk("w_mready", 64'(mr2), 64'(2'b01));
        if (mr2 != 2'b00) sb_pop("w_ack", (mr2 == 2'b10) ? 1 : 0, mrd2);
        if (sv2 && sr2 && sws2 != 4'h0) mem_word = swd2;
        next_cycle();
        sr2 = 1'b0;
        mv2 = 2'b10;
        settle();
        for (int s = 0; s < 3; s++) begin
            next_cycle();
            settle();
            chk($sformatf("r_stall%0d_svalid", s), 64'(sv2), 64'(1));
            chk($sformatf("r_stall%0d_saddr", s), 64'(sa2), 64'(32'h80));
            chk($sformatf("r_stall%0d_wstrb", s), 64'(sws2), 64'(0));
            chk($sformatf("r_stall%0d_mready", s), 64'(mr2), 64'(0));
        end
        next_cycle();
        sr2  = 1'b1;
        srd2 = mem_word;
        sb_push(1, 32'hDEAD_BEEF);
        got_ack = 1'b0;
        for (int w = 0; w < 8 && !got_ack; w++) begin
            if (w != 0) next_cycle();
            settle();
            if (mr2 != 2'b00) begin
                got_ack = 1'b1;
                chk("r_mready", 64'(mr2), 64'(2'b10));
                sb_pop("r_ack", (mr2 == 2'b10) ? 1 : 0, mrd2);
            end
        end
        if (!got_ack) begin
            checks++;
            errors++;
            $display("FAIL r_ack_timeout: got no m_ready expected m_ready[1] within 8 cycles");
        end

        // ---------------- N=2: reset while master 1 owns the bus ----------------
        next_cycle();
        sr2 = 1'b0;
        mv2 = 2'b01;
        settle();
        next_cycle();
        sr2 = 1'b1;
        settle();
        chk("b_m0_mready", 64'(mr2), 64'(2'b01));
        next_cycle();
        sr2 = 1'b0;
        mv2 = 2'b11;
        settle();
        next_cycle();
        settle();
        chk("b_owner1", 64'(gr2), 64'(2'b10));
        next_cycle();
        rst2 = 1'b1;
        settle();
        next_cycle();
        rst2 = 1'b0;
        sr2  = 1'b1;
        settle();
        chk("b_rst_grant", 64'(gr2), 64'(0));
        chk("b_rst_svalid", 64'(sv2), 64'(0));
        chk("b_rst_mready", 64'(mr2), 64'(0));
        chk("b_rst_busy", 64'(busy2), 64'(0));
        next_cycle();
        sr2 = 1'b0;
        settle();
        chk("b_ptr_reset_grant", 64'(gr2), 64'(2'b01));
        next_cycle();
        mv2 = 2'b00;
        settle();
        chk("t2_sb_drained", 64'(sbq.size()), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
